// File: rtl/arbitro_periferico.sv
// Two-requester round-robin arbiter for a four-phase peripheral handshake.
// Optional REQ-state abort timer enabled with `define ARB_TIMEOUT_EN.
module arbitro_periferico #(
  parameter int DATA_W      = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send0,
  input  logic              send1,
  input  logic [DATA_W-1:0] dados0,
  input  logic [DATA_W-1:0] dados1,
  output logic              ack0,
  output logic              ack1,
  output logic              send_p,
  output logic [DATA_W-1:0] dados_p,
  input  logic              ack_p,
  output logic              grant,
  output logic [1:0]        estadoArb,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, REL = 2'd3} state_t;

  state_t state;
  logic   last;
  logic   pick;
  logic   g_send;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick   = (send0 && send1) ? ~last : send1;
    g_send = grant ? send1 : send0;
  end

  assign estadoArb = state;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      send_p  <= 1'b0;
      dados_p <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      grant   <= 1'b0;
      last    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      err     <= 1'b0;
      cnt     <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: if (!ack_p && (send0 || send1)) begin
          grant   <= pick;
          dados_p <= pick ? dados1 : dados0;
          send_p  <= 1'b1;
          state   <= REQ;
`ifdef ARB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        // A requester dropping send here is ignored; latched data is delivered.
        REQ: if (ack_p) begin
          if (grant) ack1 <= 1'b1;
          else       ack0 <= 1'b1;
          state <= HOLD;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          send_p <= 1'b0;
          err    <= 1'b1;
          last   <= grant;
          state  <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
`endif
        HOLD: if (!g_send) begin
          send_p <= 1'b0;
          state  <= REL;
        end
        REL: if (!ack_p) begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          last  <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_periferico.sv
// Directed self-checking bench for arbitro_periferico (both timeout builds).
module tb_arbitro_periferico;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send0 = 1'b0, send1 = 1'b0, ack_p = 1'b0;
  logic [3:0] dados0 = '0, dados1 = '0;
  logic       ack0, ack1, send_p, grant, err;
  logic [3:0] dados_p;
  logic [1:0] estadoArb;

  int checks = 0;
  int errors = 0;

  arbitro_periferico #(.DATA_W(4), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .send0(send0), .send1(send1),
    .dados0(dados0), .dados1(dados1), .ack0(ack0), .ack1(ack1),
    .send_p(send_p), .dados_p(dados_p), .ack_p(ack_p), .grant(grant),
    .estadoArb(estadoArb), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    chk("rst_state", estadoArb, 0);
    chk("rst_send_p", send_p, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    rst = 1'b1;
  endtask

  // Full handshake for requester g with immediate peripheral responses.
  task automatic xfer(input string tag, input logic g, input logic [3:0] data, input logic rearm);
    step();
    chk({tag, "_req_state"}, estadoArb, 1);
    chk({tag, "_grant"}, grant, g);
    chk({tag, "_dados_p"}, dados_p, data);
    chk({tag, "_send_p"}, send_p, 1);
    ack_p = 1'b1;
    step();
    chk({tag, "_hold_state"}, estadoArb, 2);
    chk({tag, "_hold_acks"}, {ack1, ack0}, g ? 2'b10 : 2'b01);
    if (g) send1 = 1'b0; else send0 = 1'b0;
    step();
    chk({tag, "_rel_state"}, estadoArb, 3);
    chk({tag, "_rel_send_p"}, send_p, 0);
    chk({tag, "_rel_acks"}, {ack1, ack0}, g ? 2'b10 : 2'b01);
    ack_p = 1'b0;
    step();
    chk({tag, "_idle_state"}, estadoArb, 0);
    chk({tag, "_idle_acks"}, {ack1, ack0}, 0);
    if (g) send1 = rearm; else send0 = rearm;
  endtask

  initial begin
    // Reset values
    #2;
    chk("reset_state", estadoArb, 0);
    chk("reset_send_p", send_p, 0);
    chk("reset_dados_p", dados_p, 0);
    chk("reset_acks", {ack1, ack0}, 0);
    chk("reset_grant", grant, 0);
    chk("reset_err", err, 0);
    step();
    rst = 1'b1;

    // Basic transfer, peripheral acks after 2 cycles
    send0 = 1'b1; dados0 = 4'hA;
    step();
    chk("basic_req", estadoArb, 1);
    chk("basic_send_p", send_p, 1);
    chk("basic_dados_p", dados_p, 4'hA);
    step(); step();
    chk("basic_wait", estadoArb, 1);
    chk("basic_wait_acks", {ack1, ack0}, 0);
    ack_p = 1'b1;
    step();
    chk("basic_hold", estadoArb, 2);
    chk("basic_ack0", ack0, 1);
    chk("basic_ack1", ack1, 0);
    send0 = 1'b0;
    step();
    chk("basic_rel", estadoArb, 3);
    ack_p = 1'b0;
    step();
    chk("basic_idle", estadoArb, 0);
    chk("basic_ack0_low", ack0, 0);

    // Round robin with both requesting from a fresh pointer
    do_reset();
    dados0 = 4'h3; dados1 = 4'hC; send0 = 1'b1; send1 = 1'b1;
    xfer("rr1", 1'b0, 4'h3, 1'b1);
    xfer("rr2", 1'b1, 4'hC, 1'b1);
    xfer("rr3", 1'b0, 4'h3, 1'b1);
    xfer("rr4", 1'b1, 4'hC, 1'b1);

    // Stale ack in IDLE blocks the grant
    send0 = 1'b0; send1 = 1'b0; dados1 = 4'h6;
    step();
    ack_p = 1'b1; send1 = 1'b1;
    step(); step();
    chk("stale_idle", estadoArb, 0);
    chk("stale_send_p", send_p, 0);
    ack_p = 1'b0;
    xfer("stale_go", 1'b1, 4'h6, 1'b1);

    // Same requester back-to-back
    dados1 = 4'h7;
    xfer("b2b", 1'b1, 4'h7, 1'b0);

    // send0 dropped in REQ: latched data still delivered
    send0 = 1'b1; dados0 = 4'h5;
    step();
    chk("drop_req", estadoArb, 1);
    send0 = 1'b0; dados0 = 4'hF;
    step();
    chk("drop_still_req", estadoArb, 1);
    chk("drop_dados_p", dados_p, 4'h5);
    ack_p = 1'b1;
    step();
    chk("drop_hold_ack0", ack0, 1);
    chk("drop_hold_dados", dados_p, 4'h5);
    step();
    chk("drop_rel", estadoArb, 3);
    chk("drop_rel_ack0", ack0, 1);
    ack_p = 1'b0;
    step();
    chk("drop_idle", estadoArb, 0);
    chk("drop_idle_ack0", ack0, 0);

    // Peripheral never acks
    send0 = 1'b1; dados0 = 4'h2;
    step();
    chk("to_req", estadoArb, 1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      step();
      chk("to_wait_send_p", send_p, 1);
      chk("to_wait_err", err, 0);
    end
    step();
    chk("to_abort_send_p", send_p, 0);
    chk("to_abort_err", err, 1);
    chk("to_abort_state", estadoArb, 0);
    chk("to_abort_ack0", ack0, 0);
    send0 = 1'b0;
    step();
    chk("to_err_pulse", err, 0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("noto_send_p", send_p, 1);
      chk("noto_err", err, 0);
    end
    do_reset();
    send0 = 1'b0;
    step();
`endif

    // Asynchronous reset while in HOLD
    send1 = 1'b1; dados1 = 4'h9;
    step();
    ack_p = 1'b1;
    step();
    chk("ar_hold", estadoArb, 2);
    rst = 1'b0;
    #1;
    chk("ar_state", estadoArb, 0);
    chk("ar_send_p", send_p, 0);
    chk("ar_acks", {ack1, ack0}, 0);
    chk("ar_dados_p", dados_p, 0);
    ack_p = 1'b0; send1 = 1'b0;
    step();
    rst = 1'b1;
    send0 = 1'b1; send1 = 1'b1; dados0 = 4'h1; dados1 = 4'h8;
    xfer("resume", 1'b0, 4'h1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_periferico.md
ARBITRO_PERIFERICO -- requirements
Module: arbitro_periferico

Interface
REQ-001 Parameter DATA_W, default 4, width of every data bus.
REQ-002 Parameter TIMEOUT_CYC, default 15, REQ-state cycles waiting for ack_p before abort (used only with ARB_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 send0, send1  input  1 each  requester N asserts a transfer (four-phase).
REQ-006 dados0, dados1  input  DATA_W each  requester N data, stable while sendN high.
REQ-007 ack0, ack1  output  1 each  acknowledge to requester N.
REQ-008 send_p  output  1  transfer request to the peripheral.
REQ-009 dados_p  output  DATA_W  latched data to the peripheral.
REQ-010 ack_p  input  1  peripheral acknowledge.
REQ-011 grant  output  1  index of the currently or last served requester.
REQ-012 estadoArb  output  2  state code: IDLE=0, REQ=1, HOLD=2, REL=3.
REQ-013 err  output  1  one-cycle timeout pulse.

Function
REQ-014 All outputs SHALL be registered; every transition below takes effect one clk edge after the sampled condition.
REQ-015 IDLE: with ack_p=0 and any sendN=1, arbiter SHALL select requester g, latch dadosg into dados_p, set grant=g, send_p=1, go REQ.
REQ-016 IDLE with ack_p=1 (stale ack) SHALL NOT grant; remain IDLE.
REQ-017 Simultaneous send0=send1=1 SHALL be resolved round-robin: requester other than last-served wins.
REQ-018 A single requester SHALL be granted back-to-back without waiting for the other.
REQ-019 REQ: on ack_p=1, ackg SHALL go 1, go HOLD; dados_p and send_p held.
REQ-020 REQ: sendg dropping before ack_p is a protocol violation; SHALL be ignored (transfer completes with latched data).
REQ-021 HOLD: on sendg=0, send_p SHALL go 0, go REL; ackg stays 1.
REQ-022 REL: on ack_p=0, ackg SHALL go 0, last-served pointer SHALL update to g, go IDLE.
REQ-023 Non-granted requester ack SHALL remain 0 throughout; its sendN SHALL stay pending, not lost.
REQ-024 dados_p SHALL change only on a grant in IDLE.
REQ-025 Minimum complete transfer with immediate responses: 4 cycles IDLE->REQ->HOLD->REL->IDLE.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, send_p=0, dados_p=0, ack0=ack1=0, grant=0, err=0, estadoArb=0, timeout counter=0, last-served pointer=1 (requester 0 wins first).
REQ-027 Reset asserted mid-transfer SHALL abort it with the values above; no completion signalled.
REQ-028 Operation SHALL resume on the first rising clk edge after rst=1.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: counter counts clk cycles in REQ with ack_p=0; at TIMEOUT_CYC it SHALL force send_p=0, err=1 for one cycle, pointer to g, go IDLE, ackg never raised.
REQ-030 Counter SHALL clear on every entry to REQ; a 4-bit counter suffices for the default.
REQ-031 Macro undefined: no counter, REQ waits indefinitely for ack_p, err tied to 0.

Verification
REQ-032 Reset release, send0=1 dados0=4'hA, peripheral acks after 2 cycles -> send_p=1 dados_p=A, ack0 rises, ack1 stays 0, state sequence 1,2,3,0.
REQ-033 send0=send1=1 held continuously -> grants alternate 0,1,0,1 over four transfers; dados_p matches granted requester.
REQ-034 ack_p held 1 during IDLE with send1=1 -> no grant until ack_p=0, then grant=1.
REQ-035 Assert rst=0 while in HOLD -> same-cycle (asynchronous) send_p=0, ack0=ack1=0, estadoArb=0.
REQ-036 ARB_TIMEOUT_EN, TIMEOUT_CYC=15, ack_p never rises -> send_p drops after 15 REQ cycles, err high exactly one cycle, ack0=0; without macro send_p stays 1 for 100 cycles, err=0.
REQ-037 send0 dropped in REQ before ack_p -> transfer still completes with original dados_p, ack0 pulses through HOLD/REL.
